polylut_stream: RTL and testbench
=================================

POLYLUT_STREAM -- requirements
Module: polylut_stream

Interface
REQ-001 Parameter NCH, 4, number of sub-table channels.
REQ-002 Parameter A_W, 8, address field width per channel (table depth 2^A_W).
REQ-003 Parameter E_W, 5, entry width per table.
REQ-004 Derived OUT_W = NCH*E_W (20 at defaults); IN_W = NCH*A_W (32 at defaults).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 address  in  IN_W  input beat; field c = address[c*A_W +: A_W].
REQ-008 in_mode  in  1  combine mode for this beat: 0 = concat, 1 = sum.
REQ-009 in_valid  in  1 / in_ready  out  1  input handshake.
REQ-010 M2  out  OUT_W  result / out_valid  out  1 / out_ready  in  1  output handshake.
REQ-011 cfg_we  in  1, cfg_ch  in  clog2(NCH)+1, cfg_addr  in  A_W, cfg_data  in  E_W  table write port.
REQ-012 cfg_err  out  1  sticky flag for an out-of-range cfg_ch.
REQ-013 beat_cnt  out  32  count of output beats accepted (out_valid & out_ready).

Function
REQ-014 Beat accepted when in_valid & in_ready; M2 delivered when out_valid & out_ready.
REQ-015 Pipeline has 2 stages: S1 registered table read of T_c[field_c] for all c in parallel, S2 registered combine into M2.
REQ-016 Latency from accepted beat to out_valid = 2 cycles with no backpressure; throughput 1 beat/cycle.
REQ-017 Global advance en = !out_valid | out_ready; in_ready = en; S1 and S2 both hold when en=0, including table read data.
REQ-018 in_mode travels with its beat through S1 and S2; a mode change between consecutive beats needs no bubble.
REQ-019 Concat mode: M2 = {T_{NCH-1}[f], ..., T_0[f]}.
REQ-020 Sum mode: M2 = zero-extended unsigned sum of all T_c[f_c]; width E_W+clog2(NCH) ≤ OUT_W, so no overflow or saturation.
REQ-021 M2 and out_valid hold stable while out_valid & !out_ready.
REQ-022 cfg_we with cfg_ch < NCH writes T_cfg_ch[cfg_addr] = cfg_data in that cycle, regardless of en or in_valid.
REQ-023 A write and an S1 read of the same channel and address in the same cycle return the old entry (read-first).
REQ-024 cfg_we with cfg_ch ≥ NCH is ignored and sets cfg_err; cfg_err clears only on rst.
REQ-025 beat_cnt wraps from 2^32-1 to 0.

Reset
REQ-026 rst clears S1/S2 valid bits, out_valid=0, M2=0, cfg_err=0, beat_cnt=0; in_ready=1 in the first cycle after rst deasserts.
REQ-027 Table contents are not altered by rst; rst mid-operation discards in-flight beats without emitting them.
REQ-028 cfg_we is ignored while rst=1.

Structure
REQ-029 Package polylut_pkg holds default NCH/A_W/E_W, the mode constants (MODE_CONCAT=0, MODE_SUM=1), and the clog2 helper.
REQ-030 Sub-module polylut_table: one channel, depth 2^A_W × E_W, one sync read port with enable, one write port; instantiated NCH times via generate.

Verification
REQ-031 Load T_c[a] = (a+c) mod 32 for all channels. Drive address=32'h03020100, mode 0, out_ready=1 -> after 2 cycles M2 = {5'd6,5'd4,5'd2,5'd0}, out_valid for exactly 1 cycle.
REQ-032 Same table, address=32'hFFFFFFFF, mode 1 -> M2 = 31+0+1+2 = 20'd34.
REQ-033 Stream 4 beats back-to-back with out_ready=0 from cycle 3 for 3 cycles -> in_ready=0 during the stall, no beat lost or duplicated, M2 stable, beat_cnt=4 at end.
REQ-034 Write T_0[5]=7 in the same cycle a beat reads T_0[5] (old value 5) -> that beat returns 5; the next beat returns 7.
REQ-035 cfg_ch=NCH write -> no table change, cfg_err=1 until rst.
REQ-036 Assert rst with 2 beats in flight -> no out_valid afterwards; the table still returns the loaded values.

Source files
------------

// File: rtl/polylut_pkg.sv
// polylut_pkg
// Shared defaults, combine-mode constants and a constant-foldable clog2 helper
// for the polylut_stream block.
//   NCH_DEF      default number of sub-table channels
//   A_W_DEF      default address field width per channel
//   E_W_DEF      default entry width per table
//   MODE_CONCAT  combine mode 0: channel entries concatenated
//   MODE_SUM     combine mode 1: channel entries summed
package polylut_pkg;

    localparam int NCH_DEF = 4;
    localparam int A_W_DEF = 8;
    localparam int E_W_DEF = 5;

    localparam logic MODE_CONCAT = 1'b0;
    localparam logic MODE_SUM    = 1'b1;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/polylut_table.sv
// polylut_table
// One lookup channel: 2^A_W x E_W storage with a registered read port and an
// independent write port. The read register holds when rd_en is low so that a
// stalled pipeline keeps its looked-up data. A write and a read of the same
// address in one cycle return the previous entry.
//   clk      rising-edge clock
//   rd_en    advance the read register
//   rd_addr  read address
//   rd_data  registered read data
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
module polylut_table #(
    parameter int A_W = 8,
    parameter int E_W = 5
) (
    input  logic           clk,
    input  logic           rd_en,
    input  logic [A_W-1:0] rd_addr,
    output logic [E_W-1:0] rd_data,
    input  logic           wr_en,
    input  logic [A_W-1:0] wr_addr,
    input  logic [E_W-1:0] wr_data
);

    logic [E_W-1:0] mem [2**A_W];

    // Contents and read register are intentionally not reset: table data must
    // survive rst, and the read register is qualified by the pipeline valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/polylut_stream.sv
// polylut_stream
// Two-stage streaming multi-channel lookup. Stage 1 reads every channel table
// at its own address field; stage 2 combines the entries either by
// concatenation or by unsigned sum, selected per beat.
//   clk, rst                        clock, synchronous active-high reset
//   address, in_mode                input beat (NCH address fields, mode)
//   in_valid, in_ready              input handshake
//   M2, out_valid, out_ready        result and output handshake
//   cfg_we, cfg_ch, cfg_addr,
//   cfg_data                        table write port
//   cfg_err                         sticky: write addressed a missing channel
//   beat_cnt                        number of delivered output beats (wraps)
module polylut_stream
    import polylut_pkg::*;
#(
    parameter  int NCH   = NCH_DEF,
    parameter  int A_W   = A_W_DEF,
    parameter  int E_W   = E_W_DEF,
    localparam int OUT_W = NCH * E_W,
    localparam int IN_W  = NCH * A_W,
    localparam int CH_W  = clog2(NCH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   address,
    input  logic              in_mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  M2,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [A_W-1:0]    cfg_addr,
    input  logic [E_W-1:0]    cfg_data,
    output logic              cfg_err,
    output logic [31:0]       beat_cnt
);

    localparam logic [CH_W-1:0] NCH_LIMIT = CH_W'(NCH);

    logic             en;
    logic             s1_valid;
    logic             s1_mode;
    logic [E_W-1:0]   rd_data [NCH];
    logic [OUT_W-1:0] combined;

    // Whole pipeline advances together; a stalled output freezes both stages.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic wr_en;
        assign wr_en = cfg_we && !rst && (cfg_ch == CH_W'(c));

        polylut_table #(
            .A_W (A_W),
            .E_W (E_W)
        ) u_table (
            .clk     (clk),
            .rd_en   (en),
            .rd_addr (address[c*A_W +: A_W]),
            .rd_data (rd_data[c]),
            .wr_en   (wr_en),
            .wr_addr (cfg_addr),
            .wr_data (cfg_data)
        );
    end

    // Sum width E_W+clog2(NCH) fits in OUT_W, so accumulating at OUT_W never
    // overflows.
    always_comb begin
        logic [OUT_W-1:0] cat;
        logic [OUT_W-1:0] sum;
        cat = '0;
        sum = '0;
        for (int c = 0; c < NCH; c++) begin
            cat[c*E_W +: E_W] = rd_data[c];
            sum = sum + OUT_W'(rd_data[c]);
        end
        combined = (s1_mode == MODE_SUM) ? sum : cat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mode   <= MODE_CONCAT;
            out_valid <= 1'b0;
            M2        <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_mode   <= in_mode;
            out_valid <= s1_valid;
            if (s1_valid) begin
                M2 <= combined;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (cfg_we && (cfg_ch >= NCH_LIMIT)) begin
                cfg_err <= 1'b1;
            end
            if (out_valid && out_ready) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_polylut_stream.sv
// tb_polylut_stream
// Directed stimulus for polylut_stream with a table-level reference model:
// every accepted beat is looked up in the bench's own copy of the tables and
// queued; every delivered beat is compared against the queue head.
module tb_polylut_stream;
    import polylut_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic        in_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] M2;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [7:0]  cfg_addr = '0;
    logic [4:0]  cfg_data = '0;
    logic        cfg_err;
    logic [31:0] beat_cnt;

    polylut_stream dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M2        (M2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4:0]  tbl [4][256];
    logic [19:0] exp_q [$];
    logic [19:0] got_q [$];
    logic [31:0] cnt_exp = '0;
    logic        err_exp = 1'b0;
    logic        held = 1'b0;
    logic [19:0] held_v = '0;

    initial begin
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 256; a++)
                tbl[c][a] = '0;
    end

    function automatic logic [19:0] model_out(input logic [31:0] a, input logic m);
        logic [19:0] r;
        int s;
        r = '0;
        s = 0;
        for (int c = 0; c < 4; c++) begin
            r[c*5 +: 5] = tbl[c][a[c*8 +: 8]];
            s = s + int'(tbl[c][a[c*8 +: 8]]);
        end
        return (m == MODE_SUM) ? 20'(s) : r;
    endfunction

    // Compare current outputs against the model, then advance the model with
    // whatever the coming rising edge will do.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cnt_exp = '0;
            err_exp = 1'b0;
            held    = 1'b0;
        end else begin
            check("beat_cnt", beat_cnt, cnt_exp);
            check("cfg_err", cfg_err, err_exp);
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (held) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", M2, held_v);
            end
            held = 1'b0;
            if (out_valid) begin
                check("out_has_beat", exp_q.size() != 0, 1'b1);
                if (out_ready && exp_q.size() != 0) begin
                    check("m2_model", M2, exp_q.pop_front());
                    got_q.push_back(M2);
                    cnt_exp = cnt_exp + 32'd1;
                end else if (!out_ready) begin
                    held   = 1'b1;
                    held_v = M2;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model_out(address, in_mode));
            if (cfg_we) begin
                if (cfg_ch < 3'd4) tbl[cfg_ch][cfg_addr] = cfg_data;
                else err_exp = 1'b1;
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outs(input int n);
        for (int i = 0; i < 40 && got_q.size() < n; i++) @(negedge clk);
        check("outs_arrived", got_q.size(), n);
    endtask

    logic [31:0] s_addr [4];
    logic        s_mode [4];
    logic [19:0] lit;
    logic [31:0] cnt0;
    int          idx;
    int          got;
    int          k;
    int          spur;

    initial begin
        s_addr[0] = 32'h04030201; s_mode[0] = MODE_SUM;
        s_addr[1] = 32'h10203040; s_mode[1] = MODE_CONCAT;
        s_addr[2] = 32'h7F80FE01; s_mode[2] = MODE_SUM;
        s_addr[3] = 32'hAABBCCDD; s_mode[3] = MODE_CONCAT;

        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_m2", M2, 20'd0);
        check("rst_beat_cnt", beat_cnt, 32'd0);
        check("rst_cfg_err", cfg_err, 1'b0);

        // Load T_c[a] = (a + c) mod 32
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 256; a++) begin
                tick();
                cfg_we   = 1'b1;
                cfg_ch   = 3'(c);
                cfg_addr = 8'(a);
                cfg_data = 5'((a + c) % 32);
            end
        end
        tick();
        cfg_we = 1'b0;

        // Concat beat, latency 2, single-cycle valid
        tick();
        address = 32'h03020100; in_mode = MODE_CONCAT; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_c_cycle1", out_valid, 1'b0);
        tick();
        lit = {5'd6, 5'd4, 5'd2, 5'd0};
        check("lat_c_valid", out_valid, 1'b1);
        check("concat_lit", M2, lit);
        tick();
        check("lat_c_single", out_valid, 1'b0);

        // Sum beat
        tick();
        address = 32'hFFFFFFFF; in_mode = MODE_SUM; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("lat_s_valid", out_valid, 1'b1);
        check("sum_lit", M2, 20'd34);
        repeat (3) tick();

        // Four back-to-back beats with a three-cycle output stall
        cnt0 = beat_cnt;
        got_q.delete();
        idx = 0; got = 0; k = 0;
        while (got < 4 && k < 30) begin
            tick();
            out_ready = !(k >= 3 && k < 6);
            if (idx < 4) begin
                in_valid = 1'b1; address = s_addr[idx]; in_mode = s_mode[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k >= 3 && k < 6) check("stall_in_ready", in_ready, 1'b0);
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) idx++;
            k++;
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_outs", got, 4);
        check("stream_cnt", beat_cnt - cnt0, 32'd4);
        // sum of T_c[c+1] = 1+3+5+7
        check("stream_first", got_q.size() > 0 ? got_q[0] : 20'hFFFFF, 20'd16);

        // Read-first on a same-cycle write of T_0[5]
        got_q.delete();
        tick();
        address = 32'h00000005; in_mode = MODE_CONCAT; in_valid = 1'b1;
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_addr = 8'd5; cfg_data = 5'd7;
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_outs(2);
        lit = {5'd3, 5'd2, 5'd1, 5'd5};
        check("rf_old", got_q.size() > 0 ? got_q[0] : 20'hFFFFF, lit);
        lit = {5'd3, 5'd2, 5'd1, 5'd7};
        check("rf_new", got_q.size() > 1 ? got_q[1] : 20'hFFFFF, lit);

        // Write to a missing channel
        tick();
        cfg_we = 1'b1; cfg_ch = 3'd4; cfg_addr = 8'd0; cfg_data = 5'd31;
        tick();
        cfg_ch = 3'd7; cfg_addr = 8'd1;
        tick();
        cfg_we = 1'b0;
        check("cfg_err_set", cfg_err, 1'b1);
        got_q.delete();
        address = 32'h00000000; in_mode = MODE_CONCAT; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_outs(1);
        lit = {5'd3, 5'd2, 5'd1, 5'd0};
        check("bad_ch_no_write", got_q.size() > 0 ? got_q[0] : 20'hFFFFF, lit);
        repeat (3) tick();
        check("cfg_err_sticky", cfg_err, 1'b1);

        // Reset with two beats in flight; write during reset is ignored
        tick();
        address = 32'h01010101; in_mode = MODE_SUM; in_valid = 1'b1;
        tick();
        address = 32'h02020202;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_addr = 8'd9; cfg_data = 5'd0;
        tick();
        tick();
        rst = 1'b0; cfg_we = 1'b0;
        got_q.delete();
        spur = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) spur++;
        end
        check("flush_no_valid", spur, 0);
        check("flush_no_outs", got_q.size(), 0);
        check("rst_clears_err", cfg_err, 1'b0);
        check("rst_clears_cnt", beat_cnt, 32'd0);
        tick();
        address = 32'h09090909; in_mode = MODE_SUM; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_outs(1);
        check("table_kept", got_q.size() > 0 ? got_q[0] : 20'hFFFFF, 20'd42);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
